icache_miss_req_queue: RTL and testbench
========================================

Name: icache_miss_req_queue

Overview:
- Buffers the single winning miss/refill request from the icache fixed-priority valid-ready arbiter and issues it to the L2/bus request port.
- Arbiter side: its master output (vld_m/pld_m) drives this block's vld_s/pld_s. This block's rdy_s drives the arbiter's rdy_m.
- rdy_s is a function of internal state and flush only; it never depends on vld_s. This breaks the combinational valid/ready path through the arbiter.
- Issue is throttled by an outstanding-request credit counter, which completion pulses return.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- PLD_WIDTH, 32, request payload width in bits.
- MAX_OUTSTANDING, 4, maximum number of issued requests not yet completed; at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- vld_s  in  1  request valid from the arbiter.
- pld_s  in  PLD_WIDTH  request payload from the arbiter.
- rdy_s  out  1  queue can accept a request.
- vld_m  out  1  request valid to the bus.
- pld_m  out  PLD_WIDTH  request payload to the bus.
- rdy_m  in  1  bus accepts the request.
- resp_vld  in  1  one-cycle pulse: one outstanding request has completed.
- flush  in  1  discard all queued, un-issued requests.
- occupancy  out  $clog2(DEPTH+1)  number of queued entries.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  number of in-flight requests.
- err_underflow  out  1  sticky flag: resp_vld arrived while outstanding==0.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr, rd_ptr, occupancy, outstanding and err_underflow are 0. Hence rdy_s=1 and vld_m=0 once reset deasserts. Storage array is not reset.
- rdy_s = (occupancy != DEPTH) && !flush.
  - No pass-through when full: a pop in the same cycle does not raise rdy_s.
- push = vld_s && rdy_s.
  - Writes pld_s to mem[wr_ptr]; wr_ptr increments mod DEPTH.
- vld_m = (occupancy != 0) && (outstanding != MAX_OUTSTANDING) && !flush.
- pld_m = mem[rd_ptr]; the value is don't-care when vld_m=0.
- pop = vld_m && rdy_m.
  - rd_ptr increments mod DEPTH.
  - outstanding increments.
- Latency: a push in cycle N is visible on vld_m in cycle N+1 (no bypass). Sustained throughput is 1 request per cycle when credits are available.
- Pointer wrap: log2(DEPTH)-bit pointers wrap naturally. Full/empty is decided by occupancy, not by comparing pointers.
- Occupancy update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Outstanding update:
  - +1 on pop only.
  - -1 on resp_vld only, when outstanding > 0.
  - Unchanged on simultaneous pop and resp_vld.
  - resp_vld with outstanding==0 and no pop in that cycle: counter stays 0 and err_underflow is set until reset.
  - resp_vld with outstanding==0 and a pop in the same cycle: net 0, no error.
- Credit stall: when outstanding==MAX_OUTSTANDING, vld_m=0 even when the queue is non-empty. A resp_vld in cycle N re-enables vld_m in cycle N+1.
- flush (level, one or more cycles):
  - vld_m=0 and rdy_s=0 combinationally, so no handshake occurs in a flush cycle.
  - At the next edge, wr_ptr, rd_ptr and occupancy clear to 0.
  - outstanding is unaffected: in-flight requests still return, and resp_vld continues to decrement it during flush.
- vld_m stability: once asserted, vld_m and pld_m hold until pop, unless flush or reset intervenes.
- Reset asserted mid-operation discards all state immediately, including in-flight counts.

Decomposition:
- Package icache_pkg holds ICACHE_MRQ_DEPTH and ICACHE_MAX_OUTSTANDING defaults, plus the miss request payload struct (line address, way, thread id). Its width sets PLD_WIDTH at instantiation.
- Sub-module icache_mrq_credit_cnt: the outstanding counter, with inc/dec/underflow logic and outputs outstanding and credit_avail.
- Queue storage and pointers stay in the top module.

Test Plan:
1. Reset release with rdy_m=1, push payloads 0xA0..0xA3 on back-to-back cycles -> rdy_s=1 throughout; pld_m shows 0xA0..0xA3 in order starting one cycle after the first push; outstanding reaches 4.
2. rdy_m=0, push 4 entries -> occupancy=4 and rdy_s=0; a 5th vld_s is not accepted; raise rdy_m and pop 1 -> rdy_s=1 on the following cycle only.
3. Credit stall: MAX_OUTSTANDING=4, queue 6 requests, no resp -> exactly 4 pops, then vld_m=0 with occupancy=2; one resp_vld pulse -> exactly one further pop next cycle.
4. Simultaneous pop and resp_vld with outstanding=2 -> outstanding stays 2; simultaneous push and pop with occupancy=2 -> occupancy stays 2.
5. Flush with occupancy=3 and outstanding=2, resp_vld asserted in the same cycle -> no handshakes that cycle; next cycle occupancy=0 and outstanding=1; the next push returns its own payload.
6. resp_vld with outstanding=0 -> err_underflow=1 and stays set; outstanding stays 0; an asynchronous rst_n pulse mid-stream clears all outputs to their reset values immediately.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared icache miss-request types and queue sizing defaults.
package icache_pkg;

  localparam int ICACHE_MRQ_DEPTH       = 4;
  localparam int ICACHE_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic [27:0] line_addr;
    logic [1:0]  way;
    logic [1:0]  tid;
  } icache_miss_req_t;

  localparam int ICACHE_MRQ_PLD_W = $bits(icache_miss_req_t);

endpackage

// File: rtl/icache_mrq_credit_cnt.sv
// Outstanding-request counter: pops take a credit, completion pulses return one.
module icache_mrq_credit_cnt #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] outstanding_o,
  output logic          credit_avail_o,
  output logic          err_underflow_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // inc_i is only raised while a credit is available, so no overflow check is needed.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!inc_i && dec_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else             err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign outstanding_o   = cnt_q;
  assign credit_avail_o  = (cnt_q != CW'(MAX_OUTSTANDING));
  assign err_underflow_o = err_q;

endmodule

// File: rtl/icache_miss_req_queue.sv
// Miss/refill request FIFO between the icache arbiter and the L2 request port,
// with issue throttled by an outstanding-request credit counter.
module icache_miss_req_queue
  import icache_pkg::*;
#(
  parameter int DEPTH           = ICACHE_MRQ_DEPTH,
  parameter int PLD_WIDTH       = ICACHE_MRQ_PLD_W,
  parameter int MAX_OUTSTANDING = ICACHE_MAX_OUTSTANDING,
  parameter int OW              = $clog2(DEPTH + 1),
  parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_s,
  input  logic [PLD_WIDTH-1:0] pld_s,
  output logic                 rdy_s,
  output logic                 vld_m,
  output logic [PLD_WIDTH-1:0] pld_m,
  input  logic                 rdy_m,
  input  logic                 resp_vld,
  input  logic                 flush,
  output logic [OW-1:0]        occupancy,
  output logic [CW-1:0]        outstanding,
  output logic                 err_underflow
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a transfer happens on a cycle where valid && ready; valid never
  // waits on ready, and rdy_s depends only on state and flush (never on vld_s).
  logic [PLD_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]        occ_q, occ_d;
  logic                 credit_avail;
  logic                 push, pop;

  assign rdy_s = (occ_q != OW'(DEPTH)) && !flush;
  assign vld_m = (occ_q != '0) && credit_avail && !flush;
  assign pld_m = mem_q[rd_ptr_q];
  assign push  = vld_s && rdy_s;
  assign pop   = vld_m && rdy_m;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      occ_d = occ_q + 1'b1;
      else if (!push && pop) occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is deliberately left unreset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pld_s;
  end

  icache_mrq_credit_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CW              (CW)
  ) u_credit_cnt (
    .clk             (clk),
    .rst_n           (rst_n),
    .inc_i           (pop),
    .dec_i           (resp_vld),
    .outstanding_o   (outstanding),
    .credit_avail_o  (credit_avail),
    .err_underflow_o (err_underflow)
  );

  assign occupancy = occ_q;

endmodule

// File: tb/tb_icache_miss_req_queue.sv
// Randomized and directed bench for icache_miss_req_queue against a queue-based model.
module tb_icache_miss_req_queue;
  import icache_pkg::*;

  localparam int DEPTH = ICACHE_MRQ_DEPTH;
  localparam int MAXO  = ICACHE_MAX_OUTSTANDING;
  localparam int W     = ICACHE_MRQ_PLD_W;
  localparam int OW    = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vld_s, rdy_s, vld_m, rdy_m, resp_vld, flush, err_underflow;
  logic [W-1:0]  pld_s, pld_m;
  logic [OW-1:0] occupancy;
  logic [CW-1:0] outstanding;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  int           m_out;
  bit           m_err;

  icache_miss_req_queue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vld_s         (vld_s),
    .pld_s         (pld_s),
    .rdy_s         (rdy_s),
    .vld_m         (vld_m),
    .pld_m         (pld_m),
    .rdy_m         (rdy_m),
    .resp_vld      (resp_vld),
    .flush         (flush),
    .occupancy     (occupancy),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_out = 0;
    m_err = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, compare, then advance the model.
  task automatic step(input bit v, input logic [W-1:0] p, input bit rm, input bit rsp, input bit fl);
    bit m_rdy, m_vld, m_push, m_pop;
    @(negedge clk);
    vld_s = v; pld_s = p; rdy_m = rm; resp_vld = rsp; flush = fl;
    #1;
    m_rdy = (exp_q.size() != DEPTH) && !fl;
    m_vld = (exp_q.size() != 0) && (m_out != MAXO) && !fl;
    check("rdy_s", W'(rdy_s), W'(m_rdy));
    check("vld_m", W'(vld_m), W'(m_vld));
    if (m_vld) check("pld_m", pld_m, exp_q[0]);
    check("occupancy", W'(occupancy), W'(exp_q.size()));
    check("outstanding", W'(outstanding), W'(m_out));
    check("err_underflow", W'(err_underflow), W'(m_err));
    m_push = v && m_rdy;
    m_pop  = m_vld && rm;
    if (fl) exp_q.delete();
    else begin
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(p);
    end
    if (m_pop && !rsp) m_out++;
    else if (!m_pop && rsp) begin
      if (m_out > 0) m_out--;
      else m_err = 1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy_s"}, W'(rdy_s), W'(1));
    check({tag, "_vld_m"}, W'(vld_m), W'(0));
    check({tag, "_occ"}, W'(occupancy), W'(0));
    check({tag, "_out"}, W'(outstanding), W'(0));
    check({tag, "_err"}, W'(err_underflow), W'(0));
  endtask

  task automatic random_phase(input int cycles, input int p_vld, input int p_rdy, input int p_rsp, input int p_fl);
    for (int i = 0; i < cycles; i++)
      step($urandom_range(99) < p_vld, W'($urandom), $urandom_range(99) < p_rdy,
           $urandom_range(99) < p_rsp, $urandom_range(99) < p_fl);
  endtask

  initial begin
    rst_n = 1'b0; vld_s = 0; pld_s = '0; rdy_m = 0; resp_vld = 0; flush = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Back-to-back pushes with the bus always ready.
    for (int i = 0; i < 4; i++) step(1, W'(32'hA0 + i), 1, 0, 0);
    repeat (2) step(0, '0, 1, 0, 0);
    check("t1_outstanding", W'(outstanding), W'(4));
    repeat (4) step(0, '0, 1, 1, 0);

    // Fill with the bus stalled, try a fifth push, then a single pop.
    for (int i = 0; i < 5; i++) step(1, W'(32'hB0 + i), 0, 0, 0);
    step(1, W'(32'hB5), 1, 0, 0);
    repeat (2) step(1, W'(32'hB6), 0, 0, 0);

    // Credit stall: drain until credits run out, then return one credit.
    repeat (6) step(0, '0, 1, 0, 0);
    step(1, W'(32'hC0), 1, 0, 0);
    step(1, W'(32'hC1), 1, 1, 0);
    repeat (3) step(0, '0, 1, 0, 0);

    // Flush with resp_vld in the same cycle, then a fresh push.
    step(0, '0, 1, 1, 1);
    step(1, W'(32'hD0), 0, 1, 0);
    step(0, '0, 0, 1, 0);
    repeat (3) step(0, '0, 1, 1, 0);

    // Underflow: resp with nothing outstanding is sticky.
    repeat (3) step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);

    random_phase(400, 70, 60, 30, 3);
    random_phase(200, 90, 20, 10, 1);

    // Asynchronous reset mid-stream.
    @(negedge clk);
    vld_s = 0; rdy_m = 0; resp_vld = 0; flush = 0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    random_phase(300, 60, 70, 35, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
